// File: rtl/logic_gates_arbiter.sv
// Round-robin arbiter/sequencer for a shared AND/OR/NOT gate unit.
// Two requesters compete for the unit. The winner's operands are driven onto
// the gate unit and held for SETTLE cycles. The three results are then
// captured and returned with a valid/acknowledge handshake.
module logic_gates_arbiter #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [1:0]       iReq,
  input  logic [WIDTH-1:0] iA0,
  input  logic [WIDTH-1:0] iB0,
  input  logic [WIDTH-1:0] iA1,
  input  logic [WIDTH-1:0] iB1,
  input  logic [1:0]       iAck,
  output logic [1:0]       oGnt,
  output logic [WIDTH-1:0] oGateA,
  output logic [WIDTH-1:0] oGateB,
  input  logic [WIDTH-1:0] iGateAnd,
  input  logic [WIDTH-1:0] iGateOr,
  input  logic [WIDTH-1:0] iGateNot,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [1:0]       oVld,
  output logic             oBusy
);

  // The settle counter is 4 bits wide, so SETTLE must stay within 1..15.
  if (SETTLE < 1 || SETTLE > 15) begin : gBadSettle
    $error("logic_gates_arbiter: SETTLE must be in 1..15");
  end

  // Value loaded into the settle counter at a grant edge. The results are
  // sampled on the edge where the counter reaches zero, which is SETTLE
  // edges after the grant.
  localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } stateT;

  stateT            state,      stateNext;
  logic             ptr,        ptrNext;
  logic             owner,      ownerNext;
  logic [3:0]       cnt,        cntNext;
  logic [1:0]       gntNext;
  logic [1:0]       vldNext;
  logic [WIDTH-1:0] gateANext;
  logic [WIDTH-1:0] gateBNext;
  logic [WIDTH-1:0] andNext;
  logic [WIDTH-1:0] orNext;
  logic [WIDTH-1:0] notNext;
  logic             winner;

  // Next-state and next-output logic. Every register holds its value unless a
  // state explicitly changes it. The grant pulse defaults to zero so that it
  // lasts exactly one cycle.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    ownerNext = owner;
    cntNext   = cnt;
    gntNext   = 2'b00;
    vldNext   = oVld;
    gateANext = oGateA;
    gateBNext = oGateB;
    andNext   = oAnd;
    orNext    = oOr;
    notNext   = oNot;
    winner    = ptr;

    case (state)
      IDLE: begin
        if (iReq != 2'b00) begin
          // A lone requester wins outright. On a tie, the pointer decides.
          if (iReq == 2'b01) begin
            winner = 1'b0;
          end else if (iReq == 2'b10) begin
            winner = 1'b1;
          end else begin
            winner = ptr;
          end
          gateANext = winner ? iA1 : iA0;
          gateBNext = winner ? iB1 : iB0;
          gntNext   = winner ? 2'b10 : 2'b01;
          ownerNext = winner;
          ptrNext   = ~winner;
          cntNext   = SettleInit;
          stateNext = DRIVE;
        end
      end

      DRIVE: begin
        if (cnt == 4'd0) begin
          andNext   = iGateAnd;
          orNext    = iGateOr;
          notNext   = iGateNot;
          vldNext   = owner ? 2'b10 : 2'b01;
          stateNext = RESP;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end

      RESP: begin
        // Only the owner's acknowledge closes the transaction.
        if (iAck[owner]) begin
          vldNext   = 2'b00;
          stateNext = IDLE;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and output registers with a synchronous active-low reset. A reset
  // mid-transaction drops the in-flight request, and no valid is produced for it.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      cnt    <= 4'd0;
      oGnt   <= 2'b00;
      oVld   <= 2'b00;
      oGateA <= '0;
      oGateB <= '0;
      oAnd   <= '0;
      oOr    <= '0;
      oNot   <= '0;
    end else begin
      state  <= stateNext;
      ptr    <= ptrNext;
      owner  <= ownerNext;
      cnt    <= cntNext;
      oGnt   <= gntNext;
      oVld   <= vldNext;
      oGateA <= gateANext;
      oGateB <= gateBNext;
      oAnd   <= andNext;
      oOr    <= orNext;
      oNot   <= notNext;
    end
  end

  assign oBusy = (state != IDLE);

  // At most one requester is ever granted, and at most one is ever answered.
  gntOneHot: assert property (@(posedge iClk) disable iff (!iRst_n) $onehot0(oGnt));
  vldOneHot: assert property (@(posedge iClk) disable iff (!iRst_n) $onehot0(oVld));

endmodule

// File: tb/tb_logic_gates_arbiter.sv
// Self-checking bench for logic_gates_arbiter with WIDTH=1 and SETTLE=2. The
// bench models the gate unit as combinational logic.
module tb_logic_gates_arbiter;

  logic       iClk;
  logic       iRst_n;
  logic [1:0] iReq;
  logic       iA0, iB0, iA1, iB1;
  logic [1:0] iAck;
  logic [1:0] oGnt;
  logic       oGateA, oGateB;
  logic       iGateAnd, iGateOr, iGateNot;
  logic       oAnd, oOr, oNot;
  logic [1:0] oVld;
  logic       oBusy;

  int errors = 0;
  int checks = 0;

  logic_gates_arbiter #(.WIDTH(1), .SETTLE(2)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq),
    .iA0(iA0), .iB0(iB0), .iA1(iA1), .iB1(iB1),
    .iAck(iAck), .oGnt(oGnt), .oGateA(oGateA), .oGateB(oGateB),
    .iGateAnd(iGateAnd), .iGateOr(iGateOr), .iGateNot(iGateNot),
    .oAnd(oAnd), .oOr(oOr), .oNot(oNot), .oVld(oVld), .oBusy(oBusy)
  );

  assign iGateAnd = oGateA & oGateB;
  assign iGateOr  = oGateA | oGateB;
  assign iGateNot = ~oGateA;

  // Free-running clock.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Watchdog that ends the run if the main sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       rstN;
    logic [1:0] req;
    logic       a0, b0, a1, b1;
    logic [1:0] ack;
    logic [1:0] gnt;
    logic [1:0] vld;
    logic       gA, gB, andR, orR, notR, busy;
  } vecT;

  vecT vecs [8];

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vecT v);
    iRst_n = v.rstN;
    iReq   = v.req;
    iA0    = v.a0;
    iB0    = v.b0;
    iA1    = v.a1;
    iB1    = v.b1;
    iAck   = v.ack;
  endtask

  task automatic expectGnt(input string name, input logic [1:0] exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oGnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no grant within 10 cycles, expected %0h", name, exp);
    end else begin
      checkOutput(name, 8'(oGnt), 8'(exp));
    end
  endtask

  // Wait for the response, check it, acknowledge it, and check the return to idle.
  task automatic runResp(input string name, input logic [1:0] expVld,
                         input logic expAnd, input logic expOr, input logic expNot);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oVld != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s.vld: no valid within 10 cycles, expected %0h", name, expVld);
    end else begin
      checkOutput({name, ".vld"}, 8'(oVld), 8'(expVld));
      checkOutput({name, ".and"}, 8'(oAnd), 8'(expAnd));
      checkOutput({name, ".or"},  8'(oOr),  8'(expOr));
      checkOutput({name, ".not"}, 8'(oNot), 8'(expNot));
    end
    iAck = expVld;
    step();
    iAck = 2'b00;
    checkOutput({name, ".vldClr"}, 8'(oVld), 8'h00);
    checkOutput({name, ".idle"},   8'(oBusy), 8'h00);
  endtask

  initial begin
    logic [1:0] pair [2];
    logic       expOwner;
    logic       sawVld;
    logic       ea, eb;

    // Reset, then one complete transaction for requester 0 with a stray ack.
    //          rst req   a0 b0 a1 b1 ack  | gnt   vld   gA gB and or not busy
    vecs[0] = '{1'b0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1'b0, 2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0};
    vecs[2] = '{1'b1, 2'b01, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 0, 0, 0, 1};
    vecs[3] = '{1'b1, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 1};
    vecs[4] = '{1'b1, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 1, 0, 1};
    vecs[5] = '{1'b1, 2'b00, 1, 0, 0, 0, 2'b10, 2'b00, 2'b01, 1, 0, 0, 1, 0, 1};
    vecs[6] = '{1'b1, 2'b00, 1, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0};
    vecs[7] = '{1'b1, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0};

    iRst_n = 1'b0; iReq = 2'b00; iAck = 2'b00;
    iA0 = 1'b0; iB0 = 1'b0; iA1 = 1'b0; iB1 = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d.gnt", i),  8'(oGnt),   8'(vecs[i].gnt));
      checkOutput($sformatf("vec%0d.vld", i),  8'(oVld),   8'(vecs[i].vld));
      checkOutput($sformatf("vec%0d.gA", i),   8'(oGateA), 8'(vecs[i].gA));
      checkOutput($sformatf("vec%0d.gB", i),   8'(oGateB), 8'(vecs[i].gB));
      checkOutput($sformatf("vec%0d.and", i),  8'(oAnd),   8'(vecs[i].andR));
      checkOutput($sformatf("vec%0d.or", i),   8'(oOr),    8'(vecs[i].orR));
      checkOutput($sformatf("vec%0d.not", i),  8'(oNot),   8'(vecs[i].notR));
      checkOutput($sformatf("vec%0d.busy", i), 8'(oBusy),  8'(vecs[i].busy));
    end

    // Contention: both requests held, so the pointer must alternate grants.
    // Reset first so that the pointer starts back at requester 0.
    iRst_n = 1'b0;
    step();
    iRst_n = 1'b1;
    pair[0] = 2'b00;
    pair[1] = 2'b00;
    expOwner = 1'b0;
    iReq = 2'b11;
    for (int t = 0; t < 8; t++) begin
      iA0 = pair[0][1]; iB0 = pair[0][0];
      iA1 = pair[1][1]; iB1 = pair[1][0];
      expectGnt($sformatf("cont%0d.gnt", t), expOwner ? 2'b10 : 2'b01);
      ea = pair[expOwner][1];
      eb = pair[expOwner][0];
      checkOutput($sformatf("cont%0d.gA", t), 8'(oGateA), 8'(ea));
      checkOutput($sformatf("cont%0d.gB", t), 8'(oGateB), 8'(eb));
      step();
      checkOutput($sformatf("cont%0d.pulse", t), 8'(oGnt), 8'h00);
      runResp($sformatf("cont%0d", t), expOwner ? 2'b10 : 2'b01, ea & eb, ea | eb, ~ea);
      pair[expOwner] = pair[expOwner] + 2'b01;
      expOwner = ~expOwner;
    end
    iReq = 2'b00;
    step();

    // Wrong acknowledge: the non-owner's ack must not release the response.
    iReq = 2'b10; iA1 = 1'b1; iB1 = 1'b1;
    expectGnt("wack.gnt", 2'b10);
    iReq = 2'b00;
    step();
    step();
    checkOutput("wack.vld", 8'(oVld), 8'h02);
    iAck = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("wack%0d.vld", i), 8'(oVld), 8'h02);
      checkOutput($sformatf("wack%0d.and", i), 8'(oAnd), 8'h01);
      checkOutput($sformatf("wack%0d.or", i),  8'(oOr),  8'h01);
      checkOutput($sformatf("wack%0d.not", i), 8'(oNot), 8'h00);
    end
    iAck = 2'b10;
    step();
    iAck = 2'b00;
    checkOutput("wack.vldClr", 8'(oVld), 8'h00);

    // Reset in DRIVE: the transaction is lost, and the pointer returns to 0.
    iReq = 2'b01; iA0 = 1'b0; iB0 = 1'b1;
    expectGnt("rmo.gnt", 2'b01);
    iReq = 2'b00;
    iRst_n = 1'b0;
    step();
    iRst_n = 1'b1;
    checkOutput("rmo.busy", 8'(oBusy),  8'h00);
    checkOutput("rmo.vld",  8'(oVld),   8'h00);
    checkOutput("rmo.gB",   8'(oGateB), 8'h00);
    sawVld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (oVld != 2'b00) sawVld = 1'b1;
    end
    checkOutput("rmo.noVld", 8'(sawVld), 8'h00);
    iReq = 2'b11; iA0 = 1'b1; iB0 = 1'b1; iA1 = 1'b1; iB1 = 1'b0;
    expectGnt("rmo.ptr", 2'b01);
    iReq = 2'b10;
    runResp("rmo.r0", 2'b01, 1'b1, 1'b1, 1'b0);
    expectGnt("rmo.gnt1", 2'b10);
    iReq = 2'b00;
    runResp("rmo.r1", 2'b10, 1'b0, 1'b1, 1'b0);

    // Hold-off: a request raised during RESP waits for the owner's ack, and
    // its operands are sampled only at the grant edge.
    iReq = 2'b01; iA0 = 1'b1; iB0 = 1'b1;
    expectGnt("hold.gnt0", 2'b01);
    iReq = 2'b00;
    step();
    step();
    checkOutput("hold.vld", 8'(oVld), 8'h01);
    iReq = 2'b10; iA1 = 1'b0; iB1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("hold%0d.gnt", i), 8'(oGnt), 8'h00);
    end
    iAck = 2'b01;
    step();
    iAck = 2'b00;
    checkOutput("hold.ackGnt", 8'(oGnt),  8'h00);
    checkOutput("hold.ackBusy", 8'(oBusy), 8'h00);
    iA1 = 1'b1; iB1 = 1'b0;
    step();
    checkOutput("hold.gnt1", 8'(oGnt),   8'h02);
    checkOutput("hold.gA",   8'(oGateA), 8'h01);
    checkOutput("hold.gB",   8'(oGateB), 8'h00);
    iReq = 2'b00;
    runResp("hold.r1", 2'b10, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
